// File: rtl/mult_seq_pkg.sv
// ============================================================================
// Module   : mult_seq_pkg
// Purpose  : Shared state encoding and default width for mult_seq.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mult_seq_pkg;

    localparam int MULT_SEQ_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mult_seq_dp.sv
// ============================================================================
// Module   : mult_seq_dp
// Purpose  : Shift-and-add datapath (multiplicand, multiplier, accumulator,
//            step counter). Honours MULT_SEQ_EARLY_EXIT_EN for the last flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_seq_dp
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_SEQ_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_step,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_last,
    output logic [2*WIDTH-1:0]   o_acc_next
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mq;
    logic [2*WIDTH-1:0] r_acc;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   w_mq_shift;
    logic [2*WIDTH-1:0] w_acc_next;

    assign w_mq_shift = r_mq >> 1;
    // Product fits in 2*WIDTH bits, so the modulo add never wraps.
    assign w_acc_next = r_mq[0] ? (r_acc + r_mcand) : r_acc;
    assign o_acc_next = w_acc_next;

`ifdef MULT_SEQ_EARLY_EXIT_EN
    assign o_last = (r_cnt == c_CNT_LAST) || (w_mq_shift == '0);
`else
    assign o_last = (r_cnt == c_CNT_LAST);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand <= '0;
            r_mq    <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_mcand <= {{WIDTH{1'b0}}, i_a};
            r_mq    <= i_b;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (i_step) begin
            r_acc   <= w_acc_next;
            r_mcand <= r_mcand << 1;
            r_mq    <= w_mq_shift;
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/mult_seq.sv
// ============================================================================
// Module   : mult_seq
// Purpose  : Sequential unsigned multiplier with start/busy/done handshake.
//            Optional macro MULT_SEQ_EARLY_EXIT_EN ends CALC once mq is empty.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult_seq
    import mult_seq_pkg::*;
#(
    parameter int WIDTH = MULT_SEQ_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   p
);

    state_t             r_state;
    state_t             w_next;
    logic               w_load;
    logic               w_step;
    logic               w_last;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               r_busy;
    logic               r_done;
    logic [2*WIDTH-1:0] r_p;

    mult_seq_dp #(
        .WIDTH      (WIDTH)
    ) u_dp (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_a        (a),
        .i_b        (b),
        .o_last     (w_last),
        .o_acc_next (w_acc_next)
    );

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // busy/done are decoded from the next state so they leave flops directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_p     <= '0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == CALC);
            r_done  <= (w_next == DONE);
            if ((r_state == CALC) && w_last) begin
                r_p <= w_acc_next;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign p    = r_p;

endmodule

`default_nettype wire

// File: tb/tb_mult_seq.sv
// ============================================================================
// Module   : tb_mult_seq
// Purpose  : Self-checking bench for mult_seq against an arithmetic model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mult_seq;

    localparam int W = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] p;

    int n_vec;
    int n_err;

    mult_seq #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycles from the sampling edge to the edge that raises done.
    function automatic int model_lat(input logic [W-1:0] mb);
`ifdef MULT_SEQ_EARLY_EXIT_EN
        int l;
        l = 1;
        for (int i = 0; i < W; i++) if (mb[i]) l = i + 1;
        return l;
`else
        return W;
`endif
    endfunction

    function automatic logic [2*W-1:0] model_prod(input logic [W-1:0] ma, input logic [W-1:0] mb);
        int prod;
        prod = int'(ma) * int'(mb);
        return prod[2*W-1:0];
    endfunction

    // Issues one operation and observes it; n counts negedges after edge k.
    task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                          output logic [2*W-1:0] p_o, output int busy_n,
                          output int done_at, output bit p_moved);
        logic [2*W-1:0] p0;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; p0 = p;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; done_at = -1; p_moved = 1'b0; p_o = 'x;
        for (int n = 0; n < 4*W + 8; n++) begin
            if (busy) busy_n++;
            if (done) begin
                done_at = n;
                p_o = p;
                break;
            end
            if (p !== p0) p_moved = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, done, p} !== {2'b00, {2*W{1'b0}}}) begin
            n_err++;
            $display("FAIL reset_state: busy=%b done=%b p=%h, want 0 0 00", busy, done, p);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        logic [2*W-1:0] got; int bn; int da; bit mv;
        run_op(4'd15, 4'd15, got, bn, da, mv);
        n_vec += 3;
        if (got !== 8'hE1) begin n_err++; $display("FAIL basic_p: got %h want e1", got); end
        if (da !== model_lat(4'd15)) begin n_err++; $display("FAIL basic_done_at: got %0d want %0d", da, model_lat(4'd15)); end
        if (bn !== model_lat(4'd15)) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want %0d", bn, model_lat(4'd15)); end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || p !== 8'hE1) begin
            n_err++;
            $display("FAIL basic_done_pulse: done=%b p=%h, want 0 e1", done, p);
        end
    endtask

    task automatic test_isolation;
        int bn; int da; bit second;
        @(negedge clk);
        start = 1'b1; a = 4'd7; b = 4'd9;
        @(negedge clk);
        start = 1'b0;
        bn = 0; da = -1; second = 1'b0;
        for (int n = 0; n < 4*W + 8; n++) begin
            if (n == 1) begin start = 1'b1; a = '0; b = '0; end
            if (n == 2) start = 1'b0;
            if (busy) bn++;
            if (done) begin da = n; break; end
            @(negedge clk);
        end
        n_vec += 3;
        if (p !== 8'h3F) begin n_err++; $display("FAIL iso_p: got %h want 3f", p); end
        if (da !== model_lat(4'd9)) begin n_err++; $display("FAIL iso_done_at: got %0d want %0d", da, model_lat(4'd9)); end
        if (bn !== model_lat(4'd9)) begin n_err++; $display("FAIL iso_busy_cycles: got %0d want %0d", bn, model_lat(4'd9)); end
        for (int n = 0; n < W + 4; n++) begin
            @(negedge clk);
            if (busy || done) second = 1'b1;
        end
        n_vec++;
        if (second !== 1'b0) begin n_err++; $display("FAIL iso_no_second_op: saw activity=%b want 0", second); end
    endtask

    task automatic test_back_to_back;
        logic [W-1:0]   pa [3];
        logic [W-1:0]   pb [3];
        logic [2*W-1:0] got [3];
        int             at [3];
        int idx; int cyc;
        pa[0] = 4'd3;  pb[0] = 4'd5;
        pa[1] = 4'd12; pb[1] = 4'd12;
        pa[2] = 4'd0;  pb[2] = 4'd9;
        idx = 0; cyc = 0;
        @(negedge clk);
        start = 1'b1; a = pa[0]; b = pb[0];
        while (idx < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                got[idx] = p; at[idx] = cyc; idx++;
                if (idx < 3) begin a = pa[idx]; b = pb[idx]; end
                else start = 1'b0;
            end
        end
        start = 1'b0;
        n_vec++;
        if (idx !== 3) begin
            n_err++;
            $display("FAIL b2b_timeout: got %0d results want 3", idx);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_vec++;
                if (got[i] !== model_prod(pa[i], pb[i])) begin
                    n_err++;
                    $display("FAIL b2b_p[%0d]: got %h want %h", i, got[i], model_prod(pa[i], pb[i]));
                end
            end
            for (int i = 1; i < 3; i++) begin
                n_vec++;
                if (at[i] - at[i-1] !== model_lat(pb[i]) + 2) begin
                    n_err++;
                    $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, at[i] - at[i-1], model_lat(pb[i]) + 2);
                end
            end
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_abort;
        logic [2*W-1:0] got; int bn; int da; bit mv; bit saw_done;
        run_op(4'd3, 4'd5, got, bn, da, mv);
        n_vec++;
        if (got !== 8'h0F) begin n_err++; $display("FAIL abort_prior_p: got %h want 0f", got); end
        @(negedge clk);
        start = 1'b1; a = 4'd10; b = 4'd6;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, p} !== {2'b00, 8'h00}) begin
            n_err++;
            $display("FAIL abort_state: busy=%b done=%b p=%h, want 0 0 00", busy, done, p);
        end
        saw_done = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < W + 3; n++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        n_vec++;
        if (saw_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: saw activity=%b want 0", saw_done); end
        run_op(4'd10, 4'd6, got, bn, da, mv);
        n_vec++;
        if (got !== 8'h3C) begin n_err++; $display("FAIL abort_rerun_p: got %h want 3c", got); end
    endtask

    task automatic test_sweep;
        logic [2*W-1:0] got; int bn; int da; bit mv;
        for (int i = 0; i < (1 << W); i++) begin
            for (int j = 0; j < (1 << W); j++) begin
                run_op(W'(i), W'(j), got, bn, da, mv);
                n_vec += 3;
                if (got !== model_prod(W'(i), W'(j))) begin
                    n_err++; $display("FAIL sweep_p %0d*%0d: got %h want %h", i, j, got, model_prod(W'(i), W'(j)));
                end
                if (da !== model_lat(W'(j))) begin
                    n_err++; $display("FAIL sweep_lat %0d*%0d: got %0d want %0d", i, j, da, model_lat(W'(j)));
                end
                if (mv !== 1'b0) begin
                    n_err++; $display("FAIL sweep_p_stable %0d*%0d: moved=%b want 0", i, j, mv);
                end
            end
        end
    endtask

    task automatic test_random;
        logic [2*W-1:0] got; int bn; int da; bit mv;
        logic [W-1:0] ra; logic [W-1:0] rb;
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom); rb = W'($urandom);
            run_op(ra, rb, got, bn, da, mv);
            n_vec += 2;
            if (got !== model_prod(ra, rb)) begin
                n_err++; $display("FAIL rand_p %0d*%0d: got %h want %h", ra, rb, got, model_prod(ra, rb));
            end
            if (bn !== model_lat(rb)) begin
                n_err++; $display("FAIL rand_busy %0d*%0d: got %0d want %0d", ra, rb, bn, model_lat(rb));
            end
            if (($urandom & 1) != 0) @(negedge clk);
        end
    endtask

    task automatic test_early_exit;
        logic [2*W-1:0] got; int bn; int da; bit mv;
        logic [W-1:0]   tb_b [3];
        logic [2*W-1:0] tp [3];
        int             tl [3];
        tb_b[0] = 4'd0; tp[0] = 8'h00;
        tb_b[1] = 4'd2; tp[1] = 8'h12;
        tb_b[2] = 4'd8; tp[2] = 8'h48;
`ifdef MULT_SEQ_EARLY_EXIT_EN
        tl[0] = 1; tl[1] = 2; tl[2] = 4;
`else
        tl[0] = W; tl[1] = W; tl[2] = W;
`endif
        for (int i = 0; i < 3; i++) begin
            run_op(4'd9, tb_b[i], got, bn, da, mv);
            n_vec += 2;
            if (got !== tp[i]) begin n_err++; $display("FAIL early_p[%0d]: got %h want %h", i, got, tp[i]); end
            if (da !== tl[i]) begin n_err++; $display("FAIL early_lat[%0d]: got %0d want %0d", i, da, tl[i]); end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset;
        test_basic;
        test_isolation;
        test_back_to_back;
        test_reset_abort;
        test_early_exit;
        test_sweep;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mult_seq.md
# mult_seq

Sequential shift-and-add unsigned multiplier with start/busy/done handshake. Replaces the combinational `a * b` product path in the Week-7 multiplier/display design. It computes the product over several clocks and holds the result stable for the existing four-digit hex seven-segment display logic. The operand width is parameterised; the display-facing build uses 4-bit operands and an 8-bit product.

## Interface
- `WIDTH`, default 4: operand width in bits; the product is 2*`WIDTH` bits. Legal range is 2–16.
- `clk`  input  1  — the design's only clock; all registers update on its rising edge.
- `rst`  input  1  — asynchronous, active-high reset.
- `start`  input  1  — request; sampled only in IDLE.
- `a`  input  `WIDTH`  — multiplicand; sampled on the same edge as `start`.
- `b`  input  `WIDTH`  — multiplier; sampled on the same edge as `start`.
- `busy`  output  1  — high while in CALC.
- `done`  output  1  — one-cycle pulse, high while in DONE.
- `p`  output  2*`WIDTH`  — registered product; holds its value until the next DONE.

## Operation
- States: IDLE, CALC, DONE.
- Internal registers:
  - `mcand` (2*`WIDTH`, zero-extended `a`)
  - `mq` (`WIDTH`, copy of `b`)
  - `acc` (2*`WIDTH`)
  - `cnt` ($clog2(`WIDTH`) bits)
- IDLE behaviour:
  - If `start`=0, remain in IDLE.
  - If `start`=1, load `mcand`←{0,`a`}, `mq`←`b`, `acc`←0, `cnt`←0, and go to CALC.
- CALC step, per edge:
  - If `mq[0]`, then `acc`←`acc`+`mcand`. The add is modulo 2^(2*`WIDTH`) and never overflows for unsigned operands.
  - `mcand`←`mcand`<<1.
  - `mq`←`mq`>>1.
  - `cnt`←`cnt`+1.
- CALC exit: on the step where `cnt`==`WIDTH`-1, load `p`←(the updated `acc`) and go to DONE.
- DONE: `done`=1 for exactly one cycle, then unconditionally go to IDLE.
- `start` is ignored in CALC and DONE, with no queuing. Changes on `a`/`b` after the sampling edge do not affect the result.
- `start` held high continuously gives back-to-back operations. A new operand pair is sampled in each IDLE cycle.
- `p` changes only on the CALC→DONE edge or on reset.
- Arithmetic is unsigned only. Operands are never sign-extended.

## Timing
- Reset values: state=IDLE; `busy`=0, `done`=0, `p`=0; `mcand`, `mq`, `acc`, `cnt` all 0.
- Reset asserted mid-operation aborts immediately. `p` is forced to 0; no `done` pulse is produced.
- `start` sampled high at edge k:
  - `busy` is high from after edge k through edge k+`WIDTH`.
  - `done` and the new `p` appear after edge k+`WIDTH`.
  - `done` falls after edge k+`WIDTH`+1.
- Throughput with `start` tied high: one result per `WIDTH`+2 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- Macro: `MULT_SEQ_EARLY_EXIT_EN`.
- Without the macro: fixed latency, always `WIDTH` CALC steps.
- With the macro defined: CALC also exits to DONE on any step whose shifted `mq` (the value after `>>1`) is zero. `p` is loaded exactly as on a normal exit.
  - Latency becomes 1 + index of the highest set bit of `b` (1 for `b`=0).
  - Example: `b`=4'b0010 gives `done` after edge k+2.
- The handshake, the DONE pulse width and the reset behaviour are identical in both builds.

## Structure
- Package `mult_seq_pkg` contains:
  - the state typedef: 2-bit enum with IDLE=2'b00, CALC=2'b01, DONE=2'b10;
  - the default width constant `MULT_SEQ_WIDTH`=4.
- Sub-module `mult_seq_dp` holds `mcand`, `mq`, `acc`, `cnt` and the adder. It takes `load`/`step` strobes and returns the `last` flag.
- The FSM, `busy`, `done` and `p` live in the `mult_seq` top.

## Test plan
- `a`=15, `b`=15, `start` pulsed at edge k → `p`=8'hE1 and `done`=1 only in the cycle after edge k+4; `busy` is high exactly 4 cycles.
- `a`=7, `b`=9 → `p`=8'h3F. During CALC, change `a`/`b` to 0 and pulse `start` → result still 8'h3F, no second operation starts, `busy` is unaffected.
- `start` tied high with pairs (3,5), (12,12), (0,9) presented each IDLE → `p` sequence 8'h0F, 8'h90, 8'h00, with `done` pulses 6 cycles apart.
- `a`=10, `b`=6 issued with a prior `p`=8'h0F; assert `rst` at edge k+2 → `p`=0, `busy`=0, no `done`. After release, `start` with (10,6) → `p`=8'h3C.
- Exhaustive 16×16 sweep (`WIDTH`=4) → `p`==`a`*`b` for every pair; `p` is stable between `done` pulses.
- With `MULT_SEQ_EARLY_EXIT_EN`:
  - `a`=9, `b`=0 → `done` after edge k+1, `p`=0.
  - `a`=9, `b`=2 → `done` after edge k+2, `p`=8'h12.
  - `a`=9, `b`=8 → `done` after edge k+4, `p`=8'h48.
